// File: rtl/audio_pkg.sv
// Shared constants and types for the audio recorder SRAM engines.
package audio_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    // The SRAM is split into two equal recording banks.
    localparam logic [17:0] BANK0_BASE = 18'd0;
    localparam logic [17:0] BANK1_BASE = 18'd128000;
    localparam logic [17:0] BANK_LEN   = 18'd128000;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        REQ,
        READ
    } play_state_t;

endpackage

// File: rtl/sram_playback_reader_if.sv
// SRAM read port: arbiter request/grant plus address, output enable and data.
interface sram_rd_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              req;
    logic              gnt;
    logic [ADDR_W-1:0] addr;
    logic              oe_n;
    logic [DATA_W-1:0] dq;

    // Reader side: issues requests and addresses, receives grant and data.
    modport master (
        output req,
        output addr,
        output oe_n,
        input  gnt,
        input  dq
    );

    // Arbiter/SRAM side.
    modport slave (
        input  req,
        input  addr,
        input  oe_n,
        output gnt,
        output dq
    );
endinterface

// File: rtl/sram_playback_reader_lrck_edge_sync.sv
// Synchronises an asynchronous LR clock into the system domain and
// emits a one-cycle registered pulse on each rising edge.
module lrck_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lrck,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the LR clock through the synchroniser and register the edge pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lrck};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end
endmodule

// File: rtl/sram_playback_reader.sv
// Playback reader: fetches one sample per LR frame from an SRAM address
// window and drives it onto both DAC channels.
module sram_playback_reader #(
    parameter int ADDR_W      = audio_pkg::ADDR_W,
    parameter int DATA_W      = audio_pkg::DATA_W,
    parameter int RD_WAIT     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iAUD_LRCK,
    input  logic              iPLAY,
    input  logic              iLOOP,
    input  logic [ADDR_W-1:0] iSTART_ADDR,
    input  logic [ADDR_W-1:0] iEND_ADDR,
    sram_rd_if.master         sram,
    output logic [DATA_W-1:0] oAUD_outL,
    output logic [DATA_W-1:0] oAUD_outR,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oUNDERRUN
);
    import audio_pkg::*;

    localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    play_state_t       state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] sample_q;
    logic              req_q;
    logic              oe_n_q;
    logic              busy_q;
    logic              done_q;
    logic              underrun_q;
    logic              lrck_rise;

    lrck_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lrck_sync (
        .clk  (iCLK),
        .rst_n(iRST_N),
        .lrck (iAUD_LRCK),
        .rise (lrck_rise)
    );

    assign sram.req   = req_q;
    assign sram.addr  = addr_q;
    assign sram.oe_n  = oe_n_q;
    assign oAUD_outL  = sample_q;
    assign oAUD_outR  = sample_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oUNDERRUN  = underrun_q;

    // Playback FSM with registered bus and status outputs.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= IDLE;
            addr_q     <= '0;
            start_q    <= '0;
            end_q      <= '0;
            wait_cnt   <= '0;
            sample_q   <= '0;
            req_q      <= 1'b0;
            oe_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Silence after the last sample has played a full frame.
                    if (lrck_rise) begin
                        sample_q <= '0;
                    end
                    if (iPLAY) begin
                        start_q <= iSTART_ADDR;
                        end_q   <= iEND_ADDR;
                        addr_q  <= iSTART_ADDR;
                        busy_q  <= 1'b1;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (!iPLAY) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (lrck_rise) begin
                        req_q <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    // A frame edge here is dropped, not queued.
                    if (lrck_rise) begin
                        underrun_q <= 1'b1;
                    end
                    if (sram.gnt) begin
                        oe_n_q   <= 1'b0;
                        wait_cnt <= CNT_W'(RD_WAIT - 1);
                        state    <= READ;
                    end
                end
                READ: begin
                    if (lrck_rise) begin
                        underrun_q <= 1'b1;
                    end
                    if (wait_cnt == '0) begin
                        sample_q <= sram.dq;
                        req_q    <= 1'b0;
                        oe_n_q   <= 1'b1;
                        if (!iPLAY) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else if (addr_q == end_q) begin
                            if (!iLOOP) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                addr_q <= start_q;
                                state  <= ARMED;
                            end
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            state  <= ARMED;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_playback_reader.sv
// Directed bench for the playback reader: SRAM model returns addr[15:0].
module tb_sram_playback_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lrck = 1'b0;
    logic        lrck1 = 1'b0;
    logic        play = 1'b0;
    logic        loop_en = 1'b0;
    logic [17:0] start_addr = '0;
    logic [17:0] end_addr = '0;
    logic        gnt_delay_en = 1'b0;
    logic        gnt_withhold = 1'b0;
    logic [15:0] out_l, out_r, out_l1, out_r1;
    logic        busy, done, underrun, busy1, done1, underrun1;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int underrun_cnt = 0;
    int req_cnt = 0;
    int req1_rises = 0;
    int underrun1_cnt = 0;
    logic req1_d = 1'b0;

    always #5 clk = ~clk;

    sram_rd_if #(.ADDR_W(18), .DATA_W(16)) sram0 ();
    sram_rd_if #(.ADDR_W(18), .DATA_W(16)) sram1 ();

    // Grant is immediate unless delayed by 3 cycles of REQ or withheld.
    assign sram0.gnt = ~gnt_withhold & (gnt_delay_en ? (req_cnt >= 3) : 1'b1);
    assign sram0.dq  = sram0.addr[15:0];
    assign sram1.gnt = 1'b1;
    assign sram1.dq  = sram1.addr[15:0];

    sram_playback_reader #(
        .ADDR_W(18), .DATA_W(16), .RD_WAIT(2), .SYNC_STAGES(2)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iAUD_LRCK(lrck), .iPLAY(play),
        .iLOOP(loop_en), .iSTART_ADDR(start_addr), .iEND_ADDR(end_addr),
        .sram(sram0), .oAUD_outL(out_l), .oAUD_outR(out_r),
        .oBUSY(busy), .oDONE(done), .oUNDERRUN(underrun)
    );

    sram_playback_reader #(
        .ADDR_W(18), .DATA_W(16), .RD_WAIT(1), .SYNC_STAGES(2)
    ) dut1 (
        .iCLK(clk), .iRST_N(rst_n), .iAUD_LRCK(lrck1), .iPLAY(play),
        .iLOOP(loop_en), .iSTART_ADDR(start_addr), .iEND_ADDR(end_addr),
        .sram(sram1), .oAUD_outL(out_l1), .oAUD_outR(out_r1),
        .oBUSY(busy1), .oDONE(done1), .oUNDERRUN(underrun1)
    );

    // Event counters and the grant-delay timer.
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (underrun) underrun_cnt++;
        if (underrun1) underrun1_cnt++;
        if (sram1.req && !req1_d) req1_rises++;
        req1_d <= sram1.req;
        req_cnt <= sram0.req ? req_cnt + 1 : 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (6) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise LRCK; output must hold prev until lat edges later, then show exp.
    task automatic frame(input string tag, input logic [15:0] prev,
                         input logic [15:0] exp, input int lat);
        lrck = 1'b1;
        repeat (lat - 1) tick();
        check({tag, "_hold"}, {16'h0, out_l}, {16'h0, prev});
        tick();
        check({tag, "_L"}, {16'h0, out_l}, {16'h0, exp});
        check({tag, "_R"}, {16'h0, out_r}, {16'h0, exp});
        lrck = 1'b0;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("rst_req", {31'h0, sram0.req}, 32'h0);
        check("rst_oe_n", {31'h0, sram0.oe_n}, 32'h1);
        check("rst_out", {16'h0, out_l}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_addr", {14'h0, sram0.addr}, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: window 10..12, no loop
        start_addr = 18'd10; end_addr = 18'd12; loop_en = 1'b0; play = 1'b1;
        tick();
        check("t1_busy", {31'h0, busy}, 32'h1);
        frame("t1_f10", 16'd0, 16'd10, 7);
        settle();
        frame("t1_f11", 16'd10, 16'd11, 7);
        settle();
        check("t1_nodone", done_cnt, 0);
        frame("t1_f12", 16'd11, 16'd12, 7);
        check("t1_done", {31'h0, done}, 32'h1);
        check("t1_busy0", {31'h0, busy}, 32'h0);
        play = 1'b0;
        settle();
        check("t1_done_cnt", done_cnt, 1);
        frame("t1_clear", 16'd12, 16'd0, 4);
        settle();

        // 2: wrapping window with loop
        start_addr = 18'h3FFFE; end_addr = 18'h00001; loop_en = 1'b1; play = 1'b1;
        tick();
        frame("t2_a", 16'h0000, 16'hFFFE, 7); settle();
        frame("t2_b", 16'hFFFE, 16'hFFFF, 7); settle();
        frame("t2_c", 16'hFFFF, 16'h0000, 7); settle();
        frame("t2_d", 16'h0000, 16'h0001, 7); settle();
        frame("t2_e", 16'h0001, 16'hFFFE, 7); settle();
        check("t2_nodone", done_cnt, 1);
        play = 1'b0;
        settle();

        // 3: delayed grant, then withheld grant across a frame
        start_addr = 18'd100; end_addr = 18'd200; loop_en = 1'b0;
        gnt_delay_en = 1'b1; play = 1'b1;
        tick();
        frame("t3_delay", 16'hFFFE, 16'd100, 10);
        settle();
        gnt_withhold = 1'b1;
        lrck = 1'b1; repeat (6) tick();
        lrck = 1'b0; repeat (6) tick();
        lrck = 1'b1; repeat (6) tick();
        lrck = 1'b0;
        check("t3_underrun", underrun_cnt, 1);
        check("t3_stalled", {16'h0, out_l}, 32'd100);
        gnt_withhold = 1'b0;
        repeat (12) tick();
        check("t3_next", {16'h0, out_l}, 32'd101);
        check("t3_underrun_once", underrun_cnt, 1);
        gnt_delay_en = 1'b0;
        frame("t3_noskip", 16'd101, 16'd102, 7);
        settle();
        play = 1'b0;
        settle();

        // 4: play dropped during READ at addr 20
        start_addr = 18'd20; end_addr = 18'd30; play = 1'b1;
        tick();
        lrck = 1'b1;
        repeat (5) tick();
        check("t4_oe0", {31'h0, sram0.oe_n}, 32'h0);
        play = 1'b0;
        tick();
        check("t4_oe1", {31'h0, sram0.oe_n}, 32'h0);
        tick();
        check("t4_oe_off", {31'h0, sram0.oe_n}, 32'h1);
        check("t4_out", {16'h0, out_l}, 32'd20);
        check("t4_busy", {31'h0, busy}, 32'h0);
        lrck = 1'b0;
        settle();
        check("t4_nodone", done_cnt, 1);

        // 5: reset pulse during READ
        start_addr = 18'd40; end_addr = 18'd50; play = 1'b1;
        tick();
        lrck = 1'b1;
        repeat (5) tick();
        check("t5_in_read", {31'h0, sram0.oe_n}, 32'h0);
        rst_n = 1'b0;
        tick();
        check("t5_oe_n", {31'h0, sram0.oe_n}, 32'h1);
        check("t5_req", {31'h0, sram0.req}, 32'h0);
        check("t5_out", {16'h0, out_l}, 32'h0);
        check("t5_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        lrck = 1'b0;
        settle();
        frame("t5_restart", 16'd0, 16'd40, 7);
        settle();
        play = 1'b0;
        settle();

        // 6: RD_WAIT=1 instance, jittered LRCK near the clock edge
        start_addr = 18'd500; end_addr = 18'd600; loop_en = 1'b0; play = 1'b1;
        tick();
        req1_rises = 0;
        for (int i = 0; i < 16; i++) begin
            repeat (7) @(posedge clk);
            @(negedge clk);
            #($urandom_range(0, 4));
            lrck1 = ~lrck1;
        end
        repeat (10) tick();
        check("t6_fetches", req1_rises, 8);
        check("t6_out", {16'h0, out_l1}, 32'd507);
        check("t6_underrun", underrun1_cnt, 0);
        play = 1'b0;
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
